cordic_iter: RTL and testbench

//  Iterative CORDIC engine, one micro-rotation per clock; parametrised successor of the combinational rotator.
//  Two modes: ROTATION (rotate vector by angle) and VECTORING (magnitude/angle of vector).

---
 rtl/cordic_iter.sv | 222 ++++++++++++++++++++++
 tb/tb_cordic_iter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter.sv
// Iterative CORDIC rotator/vectorer, one micro-rotation per clock; result ITER+1 cycles after accept.
// Result is held in DONE until out_ready; define CORDIC_GAIN_COMP_EN for an extra 1/K compensation cycle.
module cordic_iter #(
    parameter int DATA_W  = 11,
    parameter int ANGLE_W = 9,
    parameter int FRAC_W  = 8,
    parameter int ITER    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic signed [DATA_W-1:0]  in_x,
    input  logic signed [DATA_W-1:0]  in_y,
    input  logic signed [ANGLE_W-1:0] in_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_x,
    output logic signed [DATA_W-1:0]  out_y,
    output logic signed [ANGLE_W-1:0] out_z,
    output logic                      busy
);
    localparam int W  = DATA_W + FRAC_W + 2;
    localparam int QW = W - FRAC_W;
    localparam int SH = 32 - ANGLE_W;
    localparam logic signed [ANGLE_W-1:0] Z_QTR  = ANGLE_W'(1 << (ANGLE_W - 2));
    localparam logic signed [ANGLE_W-1:0] Z_HALF = ANGLE_W'(1 << (ANGLE_W - 1));
    localparam logic signed [QW-1:0]      O_MAX  = QW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [QW-1:0]      O_MIN  = QW'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP, S_DONE} state_t;

    // atan(2^-i) as a fraction of a full turn, scaled by 2^32
    function automatic logic [31:0] atan32(input logic [4:0] i);
        logic [31:0] c;
        case (i)
            5'd0:    c = 32'h2000_0000;
            5'd1:    c = 32'h12E4_051E;
            5'd2:    c = 32'h09FB_385B;
            5'd3:    c = 32'h0511_11D4;
            5'd4:    c = 32'h028B_0D43;
            5'd5:    c = 32'h0145_D7E1;
            5'd6:    c = 32'h00A2_F61E;
            5'd7:    c = 32'h0051_7C55;
            5'd8:    c = 32'h0028_BE53;
            5'd9:    c = 32'h0014_5F2F;
            5'd10:   c = 32'h000A_2F98;
            5'd11:   c = 32'h0005_17CC;
            5'd12:   c = 32'h0002_8BE6;
            5'd13:   c = 32'h0001_45F3;
            5'd14:   c = 32'h0000_A2FA;
            5'd15:   c = 32'h0000_517D;
            default: c = 32'h0;
        endcase
        return c;
    endfunction

    function automatic logic signed [ANGLE_W-1:0] atan_step(input logic [4:0] i);
        logic [32:0] t;
        t = {1'b0, atan32(i)} + (33'd1 << (SH - 1));
        return ANGLE_W'(t >> SH);
    endfunction

    // Drop fraction rounding toward zero, then clamp to the output range
    function automatic logic signed [DATA_W-1:0] to_out(input logic signed [W-1:0] v);
        logic signed [QW-1:0]     q;
        logic signed [DATA_W-1:0] r;
        q = v[W-1:FRAC_W];
        if (v[W-1] && (v[FRAC_W-1:0] != '0))
            q = q + QW'(1);
        if (q > O_MAX)
            r = DATA_W'(O_MAX);
        else if (q < O_MIN)
            r = DATA_W'(O_MIN);
        else
            r = DATA_W'(q);
        return r;
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [16:0] INV_K = 17'sh04DBA;

    function automatic logic signed [W-1:0] gain_comp(input logic signed [W-1:0] v);
        logic signed [W+16:0] p;
        p = (W+17)'(v) * (W+17)'(INV_K) + (W+17)'(1 << 14);
        return W'(p >>> 15);
    endfunction
`endif

    state_t                     state_q, state_d;
    logic [4:0]                 cnt_q, cnt_d;
    logic                       mode_q, mode_d;
    logic signed [W-1:0]        x_q, x_d, y_q, y_d;
    logic signed [ANGLE_W-1:0]  z_q, z_d;
    logic signed [DATA_W-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
    logic signed [ANGLE_W-1:0]  out_z_q, out_z_d;

    logic                       accept, d_pos;
    logic signed [W-1:0]        x_ld, y_ld, x_it, y_it, xs, ys;
    logic signed [ANGLE_W-1:0]  z_ld, z_it, atan_i;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;

    // Pre-rotation by 180 deg brings the operand into the +/-90 deg convergence range
    always_comb begin
        x_ld = W'(in_x) <<< FRAC_W;
        y_ld = W'(in_y) <<< FRAC_W;
        z_ld = in_z;
        if (mode) begin
            if (in_x[DATA_W-1]) begin
                x_ld = -x_ld;
                y_ld = -y_ld;
                z_ld = in_z + Z_HALF;
            end
        end else if (in_z > Z_QTR) begin
            x_ld = -x_ld;
            y_ld = -y_ld;
            z_ld = in_z - Z_HALF;
        end else if (in_z < -Z_QTR) begin
            x_ld = -x_ld;
            y_ld = -y_ld;
            z_ld = in_z + Z_HALF;
        end
    end

    always_comb begin
        d_pos  = mode_q ? y_q[W-1] : ~z_q[ANGLE_W-1];
        xs     = x_q >>> cnt_q;
        ys     = y_q >>> cnt_q;
        atan_i = atan_step(cnt_q);
        if (d_pos) begin
            x_it = x_q - ys;
            y_it = y_q + xs;
            z_it = z_q - atan_i;
        end else begin
            x_it = x_q + ys;
            y_it = y_q - xs;
            z_it = z_q + atan_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        out_z_d = out_z_q;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ITER: begin
                x_d   = x_it;
                y_d   = y_it;
                z_d   = z_it;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_COMP;
`else
                    out_x_d = to_out(x_it);
                    out_y_d = to_out(y_it);
                    out_z_d = z_it;
                    state_d = S_DONE;
`endif
                end
            end
            S_COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
                out_x_d = to_out(gain_comp(x_q));
                out_y_d = to_out(gain_comp(y_q));
                out_z_d = z_q;
`endif
                state_d = S_DONE;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Accept overrides both IDLE and the DONE->IDLE release
        if (accept) begin
            x_d     = x_ld;
            y_d     = y_ld;
            z_d     = z_ld;
            mode_d  = mode;
            cnt_d   = 5'd0;
            state_d = S_ITER;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
            out_z_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            out_z_q <= out_z_d;
        end
    end
endmodule

// File: tb/tb_cordic_iter.sv
// Randomized and directed bench for cordic_iter against an integer CORDIC reference model.
// Honours CORDIC_GAIN_COMP_EN the same way the design does.
module tb_cordic_iter;
    localparam int DW = 11;
    localparam int AW = 9;
    localparam int FW = 8;
    localparam int IT = 8;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT      = IT + 2;
    localparam int E_ROT45  = 71;
    localparam int E_VEC45  = 141;
    localparam int E_VEC180 = 100;
    localparam int E_PRE    = -100;
`else
    localparam int LAT      = IT + 1;
    localparam int E_ROT45  = 116;
    localparam int E_VEC45  = 233;
    localparam int E_VEC180 = 165;
    localparam int E_PRE    = -165;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n, in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic signed [DW-1:0] in_x, in_y, out_x, out_y;
    logic signed [AW-1:0] in_z, out_z;

    always #5 clk = ~clk;

    cordic_iter #(.DATA_W(DW), .ANGLE_W(AW), .FRAC_W(FW), .ITER(IT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .busy(busy));

    typedef struct { int x; int y; int z; } res_t;
    res_t exp_q[$];
    int   atan_t[16];
    int   total = 0, bad = 0, cyc = 0, a_cyc = 0, last_cons = -1, ncons = 0;
    int   hx, hy, hz, lx, ly, lz;
    bit   seen = 0, held = 0, b2b = 0, acc_last = 0, auto_new = 0;

    task automatic chk(input string tag, input longint got, input longint exp, input int tol, input int modv);
        longint d;
        d = got - exp;
        total++;
        if (modv > 0) begin
            d = d % modv;
            if (d < 0) d += modv;
            if (d > modv / 2) d -= modv;
        end
        if (d < 0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int wrapz(input longint v);
        longint m, r;
        m = longint'(1) << AW;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    function automatic int sat(input longint v);
        longint hi, lo;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    // Reference: textbook CORDIC on unbounded integers, angle in 1/2^AW turns
    function automatic res_t model(input bit m, input int x, input int y, input int z);
        longint cx, cy, cz, nx, quarter, half;
        int     d;
        res_t   r;
        quarter = longint'(1) << (AW - 2);
        half    = longint'(1) << (AW - 1);
        cx = longint'(x) * (longint'(1) << FW);
        cy = longint'(y) * (longint'(1) << FW);
        cz = z;
        if (!m) begin
            if (z > quarter) begin cx = -cx; cy = -cy; cz = z - half; end
            else if (z < -quarter) begin cx = -cx; cy = -cy; cz = z + half; end
        end else if (x < 0) begin
            cx = -cx; cy = -cy; cz = wrapz(z + half);
        end
        for (int i = 0; i < IT; i++) begin
            d  = m ? ((cy < 0) ? 1 : -1) : ((cz >= 0) ? 1 : -1);
            nx = cx - d * (cy >>> i);
            cy = cy + d * (cx >>> i);
            cx = nx;
            cz = wrapz(cz - d * atan_t[i]);
        end
`ifdef CORDIC_GAIN_COMP_EN
        cx = (cx * 19898 + 16384) >>> 15;
        cy = (cy * 19898 + 16384) >>> 15;
`endif
        r.x = sat(cx / (longint'(1) << FW));
        r.y = sat(cy / (longint'(1) << FW));
        r.z = int'(cz);
        return r;
    endfunction

    task automatic new_op();
        mode = 1'($urandom);
        in_x = DW'($urandom);
        in_y = DW'($urandom);
        in_z = AW'($urandom);
    endtask

    // One clock: monitor at negedge, then advance past the rising edge
    task automatic step();
        bit   acc, cons;
        res_t e;
        @(negedge clk);
        acc  = in_valid && in_ready;
        cons = out_valid && out_ready;
        if (out_valid) begin
            if (!seen) begin
                chk("latency", cyc - a_cyc, LAT, 0, 0);
                seen = 1;
            end
            if (held) begin
                chk("hold_x", out_x, hx, 0, 0);
                chk("hold_y", out_y, hy, 0, 0);
                chk("hold_z", out_z, hz, 0, 0);
            end
            if (!out_ready) chk("in_ready_stall", in_ready, 0, 0, 0);
            hx = out_x; hy = out_y; hz = out_z;
            held = !cons;
        end else begin
            held = 0;
        end
        if (cons) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0, 0, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_x", out_x, e.x, 2, 0);
                chk("out_y", out_y, e.y, 2, 0);
                chk("out_z", out_z, e.z, 1, 1 << AW);
            end
            if (b2b && last_cons >= 0) chk("b2b_period", cyc - last_cons, LAT, 0, 0);
            last_cons = cyc;
            lx = out_x; ly = out_y; lz = out_z;
            ncons++;
            seen = 0;
        end
        if (acc) begin
            exp_q.push_back(model(mode, in_x, in_y, in_z));
            a_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        acc_last = acc;
        if (acc && auto_new) new_op();
    endtask

    task automatic run_dir(input bit m, input int x, input int y, input int z);
        int n0;
        n0 = ncons;
        mode = m; in_x = DW'(x); in_y = DW'(y); in_z = AW'(z);
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 40 && ncons == n0; k++) begin
            step();
            if (acc_last) in_valid = 0;
        end
        in_valid = 0;
        if (ncons == n0) chk("dir_timeout", 0, 1, 0, 0);
    endtask

    initial begin
        int n0;
        bit stale;
        for (int i = 0; i < 16; i++)
            atan_t[i] = int'($floor($atan(2.0 ** (-i)) / (2.0 * 3.141592653589793) * (2.0 ** AW) + 0.5));
        rst_n = 0; in_valid = 0; out_ready = 0; mode = 0; in_x = '0; in_y = '0; in_z = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1, 0, 0);
        chk("rst_out_valid", out_valid, 0, 0, 0);
        chk("rst_busy", busy, 0, 0, 0);
        chk("rst_out_x", out_x, 0, 0, 0);
        chk("rst_out_z", out_z, 0, 0, 0);
        rst_n = 1;

        run_dir(0, 100, 0, 64);
        chk("rot45_x", lx, E_ROT45, 2, 0);
        chk("rot45_y", ly, E_ROT45, 2, 0);
        chk("rot45_z", lz, 0, 1, 1 << AW);
        run_dir(1, 100, 100, 0);
        chk("vec45_x", lx, E_VEC45, 2, 0);
        chk("vec45_y", ly, 0, 2, 0);
        chk("vec45_z", lz, 64, 1, 1 << AW);
        run_dir(1, -100, 0, 0);
        chk("vec180_x", lx, E_VEC180, 2, 0);
        chk("vec180_z", lz, -256, 1, 1 << AW);
        run_dir(0, 100, 0, -256);
        chk("prerot_x", lx, E_PRE, 2, 0);
        chk("prerot_y", ly, 0, 2, 0);
`ifndef CORDIC_GAIN_COMP_EN
        run_dir(0, 1023, 1023, 0);
        chk("satp_x", lx, 1023, 0, 0);
        chk("satp_y", ly, 1023, 0, 0);
        run_dir(0, -1024, -1024, 0);
        chk("satn_x", lx, -1024, 0, 0);
        chk("satn_y", ly, -1024, 0, 0);
`endif
        // Exactly +/-90 deg stays unrotated; one step past it takes the pre-rotation path
        run_dir(0, 500, -300, 128);
        run_dir(0, 500, -300, -128);
        run_dir(0, 500, -300, 129);
        run_dir(0, -700, 400, -129);
        run_dir(1, 0, -500, 0);
        run_dir(1, -1, 0, 255);

        // Stall in DONE, then release into a back-to-back stream
        mode = 0; in_x = DW'(300); in_y = DW'(-200); in_z = AW'(30);
        in_valid = 1; out_ready = 0;
        for (int k = 0; k < 40 && !out_valid; k++) begin
            step();
            if (acc_last) in_valid = 0;
        end
        if (!out_valid) chk("bp_timeout", 0, 1, 0, 0);
        repeat (5) begin
            step();
            chk("bp_valid", out_valid, 1, 0, 0);
        end
        new_op();
        in_valid = 1; out_ready = 1; b2b = 1; last_cons = -1; auto_new = 1;
        n0 = ncons;
        step();
        chk("bp_release", ncons - n0, 1, 0, 0);
        chk("bp_accept", acc_last, 1, 0, 0);
        for (int k = 0; k < 200 && ncons < n0 + 7; k++) step();
        chk("b2b_count", ncons - n0, 7, 0, 0);
        b2b = 0; in_valid = 0;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) step();

        // Random valid/ready traffic
        new_op();
        n0 = ncons;
        for (int k = 0; k < 3000 && ncons < n0 + 40; k++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        chk("rand_count", ncons - n0, 40, 0, 0);
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) step();
        auto_new = 0;

        // Reset in the middle of an operation
        new_op();
        in_valid = 1;
        step();
        in_valid = 0;
        chk("mid_accept", acc_last, 1, 0, 0);
        repeat (3) step();
        rst_n = 0;
        step();
        chk("mid_busy", busy, 0, 0, 0);
        chk("mid_out_valid", out_valid, 0, 0, 0);
        chk("mid_out_x", out_x, 0, 0, 0);
        chk("mid_out_y", out_y, 0, 0, 0);
        chk("mid_out_z", out_z, 0, 0, 0);
        chk("mid_in_ready", in_ready, 1, 0, 0);
        rst_n = 1;
        exp_q.delete();
        seen = 0; held = 0; stale = 0;
        repeat (IT + 4) begin
            step();
            stale |= out_valid;
        end
        chk("no_stale", stale, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
